// File: rtl/alu_sweep_controller_if.sv
// alu_sweep_controller_if: board controls, ALU select/result handshake and sweep status.
// master is the sweep controller, slave is the board/ALU side.
interface alu_sweep_controller_if;
    logic        SWP_start;
    logic        SWP_step_mode;
    logic        SWP_step;
    logic        SWP_abort;
    logic [31:0] SWP_alu_result;
    logic        SWP_alu_ovf;
    logic        SWP_alu_zero;
    logic [2:0]  SWP_alu_op;
    logic [2:0]  SWP_alu_sel;
    logic        SWP_busy;
    logic        SWP_done;
    logic        SWP_vec_valid;
    logic [31:0] SWP_vec_result;
    logic [31:0] SWP_checksum;
    logic [6:0]  SWP_ovf_count;
    logic [6:0]  SWP_zero_count;
    modport master (
        input  SWP_start, SWP_step_mode, SWP_step, SWP_abort,
        input  SWP_alu_result, SWP_alu_ovf, SWP_alu_zero,
        output SWP_alu_op, SWP_alu_sel, SWP_busy, SWP_done, SWP_vec_valid,
        output SWP_vec_result, SWP_checksum, SWP_ovf_count, SWP_zero_count
    );
    modport slave (
        output SWP_start, SWP_step_mode, SWP_step, SWP_abort,
        output SWP_alu_result, SWP_alu_ovf, SWP_alu_zero,
        input  SWP_alu_op, SWP_alu_sel, SWP_busy, SWP_done, SWP_vec_valid,
        input  SWP_vec_result, SWP_checksum, SWP_ovf_count, SWP_zero_count
    );
endinterface

// File: rtl/alu_sweep_controller.sv
// alu_sweep_controller: steps the ALU through all 64 sel/op vectors, settling each
// before capture, and folds results into a rotating checksum and flag counters.
module alu_sweep_controller #(
    parameter int SETTLE = 4
) (
    input logic SWP_clk,
    input logic SWP_rst_n,
    alu_sweep_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLING, WAIT_STEP, DONE} state_t;
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);
    state_t      state;
    logic [5:0]  idx;
    logic [3:0]  cnt;
    logic        busy, done, vec_valid;
    logic [31:0] vec_result, checksum;
    logic [6:0]  ovf_count, zero_count;
    // idx is a register, so op/sel taken straight from it are registered outputs
    assign bus.SWP_alu_sel    = idx[5:3];
    assign bus.SWP_alu_op     = idx[2:0];
    assign bus.SWP_busy       = busy;
    assign bus.SWP_done       = done;
    assign bus.SWP_vec_valid  = vec_valid;
    assign bus.SWP_vec_result = vec_result;
    assign bus.SWP_checksum   = checksum;
    assign bus.SWP_ovf_count  = ovf_count;
    assign bus.SWP_zero_count = zero_count;
    always_ff @(posedge SWP_clk or negedge SWP_rst_n) begin
        if (!SWP_rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_valid  <= 1'b0;
            vec_result <= '0;
            checksum   <= '0;
            ovf_count  <= '0;
            zero_count <= '0;
        end else begin
            vec_valid <= 1'b0;
            if (bus.SWP_abort) begin
                state <= IDLE;
                idx   <= '0;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: if (bus.SWP_start) begin
                        state      <= SETTLING;
                        idx        <= '0;
                        cnt        <= RELOAD;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        checksum   <= '0;
                        ovf_count  <= '0;
                        zero_count <= '0;
                    end
                    SETTLING: if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        vec_result <= bus.SWP_alu_result;
                        checksum   <= {checksum[30:0], checksum[31]} ^ bus.SWP_alu_result;
                        ovf_count  <= ovf_count + 7'(bus.SWP_alu_ovf);
                        zero_count <= zero_count + 7'(bus.SWP_alu_zero);
                        vec_valid  <= 1'b1;
                        if (idx == 6'd63) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else if (bus.SWP_step_mode) begin
                            state <= WAIT_STEP;
                        end else begin
                            idx <= idx + 6'd1;
                            cnt <= RELOAD;
                        end
                    end
                    WAIT_STEP: if (bus.SWP_step) begin
                        state <= SETTLING;
                        idx   <= idx + 6'd1;
                        cnt   <= RELOAD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_sweep_controller.sv
// tb_alu_sweep_controller: directed sweeps against a bench ALU model with a
// scoreboard queue of expected captures.
module tb_alu_sweep_controller;
    localparam int ST = 4;
    typedef struct {
        logic [31:0] res;
        logic [31:0] cks;
        logic [6:0]  ovf;
        logic [6:0]  zro;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n;
    int   mode = 0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   e0 = 0;
    exp_t q[$];
    exp_t last;
    logic [31:0] saved;
    alu_sweep_controller_if bus ();
    alu_sweep_controller #(.SETTLE(ST)) dut (
        .SWP_clk  (clk),
        .SWP_rst_n(rst_n),
        .bus      (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // mode 0: real ALU model; 1: result tied to 1; 2: result 0, ovf 1, zero = op[0]
    function automatic logic [31:0] alu_res(int m, logic [2:0] s, logic [2:0] o);
        logic [31:0] a, b;
        a = 32'(2 * s + 1);
        b = 32'h605 + 32'(2 * s);
        if (m == 1) return 32'h1;
        if (m == 2) return 32'h0;
        case (o)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return a ^ b;
            3'd3: return a - b;
            3'd4: return a + b;
            3'd5: return a << 1;
            3'd6: return ~a;
            default: return 32'h0;
        endcase
    endfunction
    function automatic logic alu_ovf(int m, logic [2:0] s, logic [2:0] o);
        return m == 2 ? 1'b1 : m == 1 ? 1'b0 : alu_res(m, s, o) >> 31 != 0;
    endfunction
    function automatic logic alu_zero(int m, logic [2:0] s, logic [2:0] o);
        return m == 2 ? o[0] : alu_res(m, s, o) == 32'h0;
    endfunction
    always_comb begin
        bus.SWP_alu_result = alu_res(mode, bus.SWP_alu_sel, bus.SWP_alu_op);
        bus.SWP_alu_ovf    = alu_ovf(mode, bus.SWP_alu_sel, bus.SWP_alu_op);
        bus.SWP_alu_zero   = alu_zero(mode, bus.SWP_alu_sel, bus.SWP_alu_op);
    end
    task automatic push_sweep(input int m);
        logic [31:0] c, r;
        logic [6:0]  o, z;
        logic [5:0]  v;
        c = '0; o = '0; z = '0;
        for (int i = 0; i < 64; i++) begin
            v = 6'(i);
            r = alu_res(m, v[5:3], v[2:0]);
            c = {c[30:0], c[31]} ^ r;
            o = o + 7'(alu_ovf(m, v[5:3], v[2:0]));
            z = z + 7'(alu_zero(m, v[5:3], v[2:0]));
            q.push_back('{r, c, o, z});
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic go();
        bus.SWP_start = 1'b1;
        @(negedge clk);
        bus.SWP_start = 1'b0;
        e0 = cyc;
    endtask
    task automatic pulse(input bit is_step);
        if (is_step) bus.SWP_step = 1'b1; else bus.SWP_start = 1'b1;
        @(negedge clk);
        bus.SWP_step = 1'b0;
        bus.SWP_start = 1'b0;
    endtask
    task automatic cap_check(input string tag, input int exp_dt);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.SWP_vec_valid && n < 300);
        chk({tag, "_valid"}, 32'(bus.SWP_vec_valid), 32'h1);
        chk({tag, "_time"}, cyc - e0, exp_dt);
        if (bus.SWP_vec_valid && q.size() > 0) begin
            last = q.pop_front();
            chk({tag, "_res"}, bus.SWP_vec_result, last.res);
            chk({tag, "_cks"}, bus.SWP_checksum, last.cks);
            chk({tag, "_ovf"}, 32'(bus.SWP_ovf_count), 32'(last.ovf));
            chk({tag, "_zero"}, 32'(bus.SWP_zero_count), 32'(last.zro));
        end
    endtask
    task automatic check_zero_outputs(input string tag);
        chk({tag, "_op"}, 32'(bus.SWP_alu_op), 0);
        chk({tag, "_sel"}, 32'(bus.SWP_alu_sel), 0);
        chk({tag, "_busy"}, 32'(bus.SWP_busy), 0);
        chk({tag, "_done"}, 32'(bus.SWP_done), 0);
        chk({tag, "_valid"}, 32'(bus.SWP_vec_valid), 0);
        chk({tag, "_vres"}, bus.SWP_vec_result, 0);
        chk({tag, "_cks"}, bus.SWP_checksum, 0);
        chk({tag, "_ovfc"}, 32'(bus.SWP_ovf_count), 0);
        chk({tag, "_zc"}, 32'(bus.SWP_zero_count), 0);
    endtask
    task automatic run_sweep(input string tag, input int m);
        mode = m;
        q.delete();
        push_sweep(m);
        go();
        chk({tag, "_start_busy"}, 32'(bus.SWP_busy), 1);
        chk({tag, "_start_done"}, 32'(bus.SWP_done), 0);
        chk({tag, "_start_cks"}, bus.SWP_checksum, 0);
        chk({tag, "_start_ovfc"}, 32'(bus.SWP_ovf_count), 0);
        chk({tag, "_start_zc"}, 32'(bus.SWP_zero_count), 0);
        chk({tag, "_start_idx"}, 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 0);
        for (int k = 0; k < 64; k++) begin
            cap_check(tag, (k + 1) * ST);
            if (m == 0 && k == 12) chk("idx12_result", bus.SWP_vec_result, 32'h0000_060A);
            if (m == 1 && k == 31) chk("cks_after32", bus.SWP_checksum, 32'hFFFF_FFFF);
            if (m == 0 && k == 10) begin
                pulse(1'b0);
                chk("start_busy_ignored", 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 11);
            end
        end
        chk({tag, "_end_done"}, 32'(bus.SWP_done), 1);
        chk({tag, "_end_busy"}, 32'(bus.SWP_busy), 0);
        chk({tag, "_end_opsel"}, 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 32'h3F);
    endtask
    initial begin
        bus.SWP_start = 1'b0;
        bus.SWP_step_mode = 1'b0;
        bus.SWP_step = 1'b0;
        bus.SWP_abort = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_zero_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep("run", 0);
        repeat (3) @(negedge clk);
        chk("done_hold", 32'(bus.SWP_done), 1);
        run_sweep("tie1", 1);
        chk("cks_after64", bus.SWP_checksum, 32'h0);
        run_sweep("flags", 2);
        chk("flags_cks", bus.SWP_checksum, 32'h0);
        chk("flags_ovfc", 32'(bus.SWP_ovf_count), 64);
        chk("flags_zc", 32'(bus.SWP_zero_count), 32);
        // asynchronous reset part-way through a sweep
        mode = 0;
        q.delete();
        push_sweep(0);
        go();
        begin
            int n;
            n = 0;
            while ({bus.SWP_alu_sel, bus.SWP_alu_op} != 6'd20 && n < 200) begin
                @(negedge clk);
                n++;
            end
        end
        chk("rst_reach20", 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 20);
        rst_n = 1'b0;
        #1 check_zero_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        q.delete();
        push_sweep(0);
        go();
        chk("rst_restart_idx", 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 0);
        cap_check("rst_cap0", ST);
        bus.SWP_abort = 1'b1;
        @(negedge clk);
        bus.SWP_abort = 1'b0;
        // step mode
        bus.SWP_step_mode = 1'b1;
        q.delete();
        push_sweep(0);
        go();
        cap_check("stp0", ST);
        repeat (100) @(negedge clk);
        chk("stp_hold_idx", 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 0);
        chk("stp_hold_busy", 32'(bus.SWP_busy), 1);
        pulse(1'b1);
        e0 = cyc;
        chk("stp_op1", 32'(bus.SWP_alu_op), 1);
        pulse(1'b1);
        cap_check("stp1", ST);
        repeat (10) @(negedge clk);
        chk("stp_settle_ignored", 32'(bus.SWP_alu_op), 1);
        saved = bus.SWP_checksum;
        pulse(1'b0);
        @(negedge clk);
        chk("stp_start_ignored_idx", 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 1);
        chk("stp_start_ignored_cks", bus.SWP_checksum, saved);
        for (int k = 2; k <= 30; k++) begin
            pulse(1'b1);
            e0 = cyc;
            cap_check("stpk", ST);
        end
        chk("stp_idx30", 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 30);
        saved = last.cks;
        bus.SWP_abort = 1'b1;
        bus.SWP_step = 1'b1;
        @(negedge clk);
        bus.SWP_abort = 1'b0;
        bus.SWP_step = 1'b0;
        chk("abort_opsel", 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 0);
        chk("abort_busy", 32'(bus.SWP_busy), 0);
        chk("abort_done", 32'(bus.SWP_done), 0);
        chk("abort_cks", bus.SWP_checksum, saved);
        chk("abort_vres", bus.SWP_vec_result, last.res);
        repeat (5) @(negedge clk);
        chk("abort_idle_idx", 32'({bus.SWP_alu_sel, bus.SWP_alu_op}), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
